uart_fifo: RTL and testbench
============================

Name: uart_fifo

Overview:
- Full-duplex UART, next generation of the fixed-rate core.
- Adds a runtime-programmable bit period, 3-sample majority voting on RX, and parity/framing/break error reporting per received word.
- TX and RX FIFOs decouple bus-side traffic from line timing.
- Sits between register/stream logic and the physical uart_rx/uart_tx pins.

Parameters:
- NR_BITS, 8, data bits per frame, 5..16.
- PARITY, "NONE", "NONE"/"EVEN"/"ODD".
- STOP_BITS, 1, stop bits transmitted, 1..2.
- DIV_WIDTH, 16, width of baud_div.
- TX_DEPTH, 16, TX FIFO words, power of 2, >=2.
- RX_DEPTH, 16, RX FIFO entries, power of 2, >=2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- baud_div  in  DIV_WIDTH  clk cycles per bit minus 1; must be >=3.
- uart_tx_d  in  NR_BITS  TX data.
- uart_tx_dv  in  1  TX data valid.
- uart_tx_dr  out  1  TX FIFO not full.
- uart_rx_d  out  NR_BITS  RX FIFO head data.
- uart_rx_err  out  3  head error flags {break, frame_err, parity_err}.
- uart_rx_dv  out  1  RX FIFO not empty.
- uart_rx_dr  in  1  consumer ready; pop on dv&&dr.
- rx_overrun  out  1  sticky, set when a word is dropped.
- err_clr  in  1  clears rx_overrun.
- tx_busy  out  1  frame on line or TX FIFO not empty.
- uart_rx  in  1  serial input, asynchronous.
- uart_tx  out  1  serial output.

Behaviour:
- Reset (async assert, sync release): uart_tx=1, uart_tx_dr=1, uart_rx_dv=0, uart_rx_d=0, uart_rx_err=0, rx_overrun=0, tx_busy=0; both FIFOs empty; both FSMs IDLE.
- Bit period P = baud_div+1. baud_div is sampled at each frame start (TX and RX independently); changes mid-frame do not affect the current frame.
- TX FIFO push: uart_tx_dv&&uart_tx_dr. Words pushed while full are ignored and not counted.
- TX FSM states: IDLE -> START -> DATA (LSB first, NR_BITS) -> PARITY (only if PARITY!="NONE") -> STOP (STOP_BITS periods) -> IDLE, or directly to START if FIFO non-empty.
- Each TX state lasts exactly P cycles.
- TX latency: push at cycle N into an empty, idle TX path -> uart_tx falls at N+2.
- Back-to-back TX frames have no idle gap beyond the STOP period(s).
- Parity: EVEN bit = XOR(data); ODD bit = ~XOR(data).
- RX input: uart_rx passes a 2-FF synchronizer; all RX timing below refers to the synchronized signal.
- RX IDLE -> START on a 1->0 edge. Bit counter restarts at 0.
- RX samples at counts M-1, M, M+1, where M = baud_div>>1. The bit value is the majority of the three.
- START majority = 1 -> glitch; return to IDLE with no push.
- RX then walks DATA -> PARITY (if enabled) -> STOP, checking only the first stop bit.
- At the STOP-bit decision, push {data, err} into the RX FIFO and return to IDLE (re-armed for the next falling edge).
  - frame_err = stop sampled 0.
  - parity_err = parity mismatch, always 0 when PARITY="NONE".
  - break = all data bits 0, parity 0 (if present) and stop 0.
- After a break, RX waits for line=1 before re-arming; no further pushes during a held break.
- RX FIFO is first-word-fall-through: uart_rx_d/uart_rx_err are valid whenever uart_rx_dv=1; pushed entry is visible at the cycle after the push.
- RX FIFO full at push: word dropped, contents unchanged, rx_overrun=1 next cycle.
- Simultaneous push and pop on a full RX FIFO: pop first, push succeeds, no overrun.
- Simultaneous err_clr and a new overrun: set wins.
- Pop on empty is ignored. FIFO pointers carry one extra wrap bit; full and empty are distinguished by the MSB.
- tx_busy = TX FIFO non-empty OR TX FSM not IDLE.
- rst_n assertion mid-frame: immediate abort. uart_tx=1 asynchronously, both FIFOs flushed, partial RX word discarded.

Test Plan:
- Loopback (uart_tx->uart_rx), baud_div=9, 8N1, push 0xA5, 0x3C, 0xFF back-to-back:
  - uart_tx low at push+2.
  - Each frame 100 cycles.
  - RX pops 0xA5, 0x3C, 0xFF, all with err=000.
- PARITY="ODD", baud_div=15, inject 0x55 with parity bit forced 0 -> uart_rx_d=0x55, uart_rx_err=001. Same frame with correct parity 1 -> err=000.
- Drive the line low for 12 bit periods, then high (baud_div=9) -> exactly one entry, d=0x00, err=110. Next valid frame 0x81 -> err=000.
- Glitch and majority voting, baud_div=9:
  - 2-cycle low pulse on an idle line -> no push.
  - 1-cycle inverted glitch at each data-bit mid sample of 0x5A -> received 0x5A.
- RX_DEPTH=4, uart_rx_dr=0, send 5 frames 0x01..0x05:
  - FIFO holds 0x01..0x04; rx_overrun=1.
  - err_clr pulse -> rx_overrun=0.
  - Pop sequence 0x01..0x04.
- Assert rst_n mid-DATA of a TX frame with 3 words queued -> uart_tx=1 without waiting for a clk edge, tx_busy=0, uart_tx_dr=1. After release, new push 0x42 is transmitted correctly.

Source files
------------

// File: rtl/uart_fifo.sv
// Full-duplex UART with programmable bit period, TX/RX FIFOs,
// 3-sample majority voting on RX and per-word break/frame/parity flags.
module uart_fifo #(
  parameter int    NR_BITS   = 8,
  parameter string PARITY    = "NONE",
  parameter int    STOP_BITS = 1,
  parameter int    DIV_WIDTH = 16,
  parameter int    TX_DEPTH  = 16,
  parameter int    RX_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [NR_BITS-1:0]   uart_tx_d,
  input  logic                 uart_tx_dv,
  output logic                 uart_tx_dr,
  output logic [NR_BITS-1:0]   uart_rx_d,
  output logic [2:0]           uart_rx_err,
  output logic                 uart_rx_dv,
  input  logic                 uart_rx_dr,
  output logic                 rx_overrun,
  input  logic                 err_clr,
  output logic                 tx_busy,
  input  logic                 uart_rx,
  output logic                 uart_tx
);

  localparam logic PAR_EN    = (PARITY != "NONE");
  localparam logic PAR_ODD   = (PARITY == "ODD");
  localparam logic LAST_STOP = (STOP_BITS == 2);
  localparam int   TAW       = $clog2(TX_DEPTH);
  localparam int   RAW       = $clog2(RX_DEPTH);
  localparam int   EW        = NR_BITS + 3;
  localparam logic [4:0]           LAST_BIT = 5'(NR_BITS - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [TAW:0]         TP_ONE   = (TAW + 1)'(1);
  localparam logic [RAW:0]         RP_ONE   = (RAW + 1)'(1);

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_PAR   = 3'd3,
    TX_STOP  = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_PAR   = 3'd3,
    RX_STOP  = 3'd4,
    RX_BRK   = 3'd5
  } rx_state_t;

  // Parity bit for a data word: even parity is the XOR, odd is its inverse.
  function automatic logic par_bit(input logic [NR_BITS-1:0] d);
    return (^d) ^ PAR_ODD;
  endfunction

  // Majority of three samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // ---------------- TX FIFO ----------------
  logic [NR_BITS-1:0] r_txf_mem [TX_DEPTH];
  logic [TAW:0]       r_txf_wr;
  logic [TAW:0]       r_txf_rd;
  logic               w_txf_empty;
  logic               w_txf_full;
  logic               w_txf_push;
  logic [NR_BITS-1:0] w_txf_head;
  logic               w_tx_load;

  assign w_txf_empty = (r_txf_wr == r_txf_rd);
  assign w_txf_full  = (r_txf_wr[TAW] != r_txf_rd[TAW]) &&
                       (r_txf_wr[TAW-1:0] == r_txf_rd[TAW-1:0]);
  assign w_txf_push  = uart_tx_dv & ~w_txf_full;
  assign w_txf_head  = r_txf_mem[r_txf_rd[TAW-1:0]];
  assign uart_tx_dr  = ~w_txf_full;

  // TX FIFO storage write port.
  always_ff @(posedge clk) begin
    if (w_txf_push) begin
      r_txf_mem[r_txf_wr[TAW-1:0]] <= uart_tx_d;
    end
  end

  // TX FIFO pointers; the read side advances whenever the FSM loads a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txf_wr <= '0;
      r_txf_rd <= '0;
    end else begin
      if (w_txf_push) r_txf_wr <= r_txf_wr + TP_ONE;
      if (w_tx_load)  r_txf_rd <= r_txf_rd + TP_ONE;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t              r_tx_state;
  logic [DIV_WIDTH-1:0]   r_tx_cnt;
  logic [DIV_WIDTH-1:0]   r_tx_div;
  logic [NR_BITS-1:0]     r_tx_sh;
  logic [4:0]             r_tx_bidx;
  logic                   r_tx_sidx;
  logic                   r_tx_par;
  logic                   r_tx;
  logic                   w_tx_bit_end;

  // Frame-start decision: load from IDLE, or chain straight out of the last stop bit.
  always_comb begin
    w_tx_bit_end = (r_tx_cnt == r_tx_div);
    if (r_tx_state == TX_IDLE) begin
      w_tx_load = ~w_txf_empty;
    end else if (r_tx_state == TX_STOP) begin
      w_tx_load = w_tx_bit_end & (r_tx_sidx == LAST_STOP) & ~w_txf_empty;
    end else begin
      w_tx_load = 1'b0;
    end
  end

  // TX frame sequencer; uart_tx is a register so the line never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_div   <= '0;
      r_tx_sh    <= '0;
      r_tx_bidx  <= 5'd0;
      r_tx_sidx  <= 1'b0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
    end else if (w_tx_load) begin
      r_tx_state <= TX_START;
      r_tx       <= 1'b0;
      r_tx_sh    <= w_txf_head;
      r_tx_par   <= par_bit(w_txf_head);
      r_tx_div   <= baud_div;
      r_tx_cnt   <= '0;
    end else if (r_tx_state == TX_IDLE) begin
      r_tx <= 1'b1;
    end else if (!w_tx_bit_end) begin
      r_tx_cnt <= r_tx_cnt + DIV_ONE;
    end else begin
      r_tx_cnt <= '0;
      case (r_tx_state)
        TX_START: begin
          r_tx_state <= TX_DATA;
          r_tx       <= r_tx_sh[0];
          r_tx_sh    <= {1'b0, r_tx_sh[NR_BITS-1:1]};
          r_tx_bidx  <= 5'd0;
        end
        TX_DATA: begin
          if (r_tx_bidx == LAST_BIT) begin
            if (PAR_EN) begin
              r_tx_state <= TX_PAR;
              r_tx       <= r_tx_par;
            end else begin
              r_tx_state <= TX_STOP;
              r_tx       <= 1'b1;
              r_tx_sidx  <= 1'b0;
            end
          end else begin
            r_tx_bidx <= r_tx_bidx + 5'd1;
            r_tx      <= r_tx_sh[0];
            r_tx_sh   <= {1'b0, r_tx_sh[NR_BITS-1:1]};
          end
        end
        TX_PAR: begin
          r_tx_state <= TX_STOP;
          r_tx       <= 1'b1;
          r_tx_sidx  <= 1'b0;
        end
        TX_STOP: begin
          if (r_tx_sidx == LAST_STOP) begin
            r_tx_state <= TX_IDLE;
            r_tx       <= 1'b1;
          end else begin
            r_tx_sidx <= 1'b1;
          end
        end
        default: begin
          r_tx_state <= TX_IDLE;
          r_tx       <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx = r_tx;
  assign tx_busy = ~w_txf_empty | (r_tx_state != TX_IDLE);

  // ---------------- RX front end ----------------
  logic r_rx_s1;
  logic r_rx_s2;
  logic r_rx_prev;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_t            r_rx_state;
  logic [DIV_WIDTH-1:0] r_rx_cnt;
  logic [DIV_WIDTH-1:0] r_rx_div;
  logic [1:0]           r_rx_smp;
  logic [NR_BITS-1:0]   r_rx_sh;
  logic                 r_rx_pbit;
  logic [4:0]           r_rx_bidx;
  logic                 r_rx_push;
  logic [EW-1:0]        r_rx_pdat;
  logic [DIV_WIDTH-1:0] w_rx_m;
  logic                 w_smp0;
  logic                 w_smp1;
  logic                 w_smp2;
  logic                 w_rx_bit_end;
  logic                 w_maj;
  logic                 w_rx_brk;
  logic                 w_rx_perr;

  // Sample-point decode and per-word error evaluation.
  always_comb begin
    w_rx_m       = r_rx_div >> 1;
    w_smp0       = (r_rx_cnt == (w_rx_m - DIV_ONE));
    w_smp1       = (r_rx_cnt == w_rx_m);
    w_smp2       = (r_rx_cnt == (w_rx_m + DIV_ONE));
    w_rx_bit_end = (r_rx_cnt == r_rx_div);
    w_maj        = maj3(r_rx_smp[0], r_rx_smp[1], r_rx_s2);
    w_rx_brk     = (r_rx_sh == {NR_BITS{1'b0}}) && !(PAR_EN && r_rx_pbit) && !w_maj;
    w_rx_perr    = PAR_EN && (r_rx_pbit != par_bit(r_rx_sh));
  end

  // RX frame walker; the word is pushed at the first stop-bit decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_div   <= '0;
      r_rx_smp   <= 2'b00;
      r_rx_sh    <= '0;
      r_rx_pbit  <= 1'b0;
      r_rx_bidx  <= 5'd0;
      r_rx_push  <= 1'b0;
      r_rx_pdat  <= '0;
    end else begin
      r_rx_push <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev & ~r_rx_s2) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= '0;
            r_rx_div   <= baud_div;
          end
        end
        RX_BRK: begin
          if (r_rx_s2) r_rx_state <= RX_IDLE;
        end
        RX_START, RX_DATA, RX_PAR, RX_STOP: begin
          if (w_rx_bit_end) r_rx_cnt <= '0;
          else              r_rx_cnt <= r_rx_cnt + DIV_ONE;
          if (w_smp0) r_rx_smp[0] <= r_rx_s2;
          if (w_smp1) r_rx_smp[1] <= r_rx_s2;
          if (w_smp2) begin
            case (r_rx_state)
              RX_START: if (w_maj) r_rx_state <= RX_IDLE;
              RX_DATA:  r_rx_sh   <= {w_maj, r_rx_sh[NR_BITS-1:1]};
              RX_PAR:   r_rx_pbit <= w_maj;
              RX_STOP: begin
                r_rx_push  <= 1'b1;
                r_rx_pdat  <= {w_rx_brk, ~w_maj, w_rx_perr, r_rx_sh};
                r_rx_state <= w_rx_brk ? RX_BRK : RX_IDLE;
              end
              default: ;
            endcase
          end
          if (w_rx_bit_end) begin
            case (r_rx_state)
              RX_START: begin
                r_rx_state <= RX_DATA;
                r_rx_bidx  <= 5'd0;
              end
              RX_DATA: begin
                if (r_rx_bidx == LAST_BIT) r_rx_state <= PAR_EN ? RX_PAR : RX_STOP;
                else                       r_rx_bidx  <= r_rx_bidx + 5'd1;
              end
              RX_PAR:  r_rx_state <= RX_STOP;
              default: ;
            endcase
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO (first-word-fall-through) ----------------
  logic [EW-1:0] r_rxf_mem [RX_DEPTH];
  logic [RAW:0]  r_rxf_wr;
  logic [RAW:0]  r_rxf_rd;
  logic          r_ovr;
  logic          w_rxf_empty;
  logic          w_rxf_full;
  logic          w_rxf_pop;
  logic          w_rxf_wr;
  logic [EW-1:0] w_rxf_head;

  assign w_rxf_empty = (r_rxf_wr == r_rxf_rd);
  assign w_rxf_full  = (r_rxf_wr[RAW] != r_rxf_rd[RAW]) &&
                       (r_rxf_wr[RAW-1:0] == r_rxf_rd[RAW-1:0]);
  assign w_rxf_pop   = ~w_rxf_empty & uart_rx_dr;
  assign w_rxf_wr    = r_rx_push & (~w_rxf_full | w_rxf_pop);
  assign w_rxf_head  = r_rxf_mem[r_rxf_rd[RAW-1:0]];

  // RX FIFO storage write port.
  always_ff @(posedge clk) begin
    if (w_rxf_wr) begin
      r_rxf_mem[r_rxf_wr[RAW-1:0]] <= r_rx_pdat;
    end
  end

  // RX FIFO pointers and sticky overrun; a new overrun beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxf_wr <= '0;
      r_rxf_rd <= '0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_rxf_wr)  r_rxf_wr <= r_rxf_wr + RP_ONE;
      if (w_rxf_pop) r_rxf_rd <= r_rxf_rd + RP_ONE;
      if (r_rx_push & w_rxf_full & ~w_rxf_pop) r_ovr <= 1'b1;
      else if (err_clr)                        r_ovr <= 1'b0;
    end
  end

  assign uart_rx_dv  = ~w_rxf_empty;
  assign uart_rx_d   = w_rxf_empty ? {NR_BITS{1'b0}} : w_rxf_head[NR_BITS-1:0];
  assign uart_rx_err = w_rxf_empty ? 3'b000 : w_rxf_head[EW-1:NR_BITS];
  assign rx_overrun  = r_ovr;

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: instance A is 8N1 with a 4-deep RX FIFO,
// instance B is 8O1; frames are driven bit-by-bit or looped back from TX.
module tb_uart_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] a_div, b_div;
  logic [7:0]  a_tx_d, b_tx_d, a_rx_d, b_rx_d;
  logic        a_tx_dv, b_tx_dv, a_tx_dr, b_tx_dr;
  logic [2:0]  a_rx_err, b_rx_err;
  logic        a_rx_dv, b_rx_dv, a_rx_dr, b_rx_dr;
  logic        a_ovr, b_ovr, a_clr, b_clr, a_busy, b_busy;
  logic        a_rx_line, a_tx_line, b_tx_line;
  logic        a_loop, a_drv, b_drv;

  assign a_rx_line = a_loop ? a_tx_line : a_drv;

  uart_fifo #(.NR_BITS(8), .PARITY("NONE"), .STOP_BITS(1), .DIV_WIDTH(16),
              .TX_DEPTH(4), .RX_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .baud_div(a_div),
    .uart_tx_d(a_tx_d), .uart_tx_dv(a_tx_dv), .uart_tx_dr(a_tx_dr),
    .uart_rx_d(a_rx_d), .uart_rx_err(a_rx_err), .uart_rx_dv(a_rx_dv),
    .uart_rx_dr(a_rx_dr), .rx_overrun(a_ovr), .err_clr(a_clr),
    .tx_busy(a_busy), .uart_rx(a_rx_line), .uart_tx(a_tx_line));

  uart_fifo #(.NR_BITS(8), .PARITY("ODD"), .STOP_BITS(1), .DIV_WIDTH(16),
              .TX_DEPTH(16), .RX_DEPTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .baud_div(b_div),
    .uart_tx_d(b_tx_d), .uart_tx_dv(b_tx_dv), .uart_tx_dr(b_tx_dr),
    .uart_rx_d(b_rx_d), .uart_rx_err(b_rx_err), .uart_rx_dv(b_rx_dv),
    .uart_rx_dr(b_rx_dr), .rx_overrun(b_ovr), .err_clr(b_clr),
    .tx_busy(b_busy), .uart_rx(b_drv), .uart_tx(b_tx_line));

  int n_vec = 0;
  int n_bad = 0;
  logic [10:0] q_a[$];
  logic [10:0] q_b[$];

  typedef struct {
    bit         sel;
    logic [7:0] data;
    bit         bad_par;
    bit         glitch;
    bit         bad_stop;
    logic [7:0] exp_d;
    logic [2:0] exp_err;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Drive one frame on A's (sel=0) or B's (sel=1) serial input, then idle 2 bits.
  task automatic send_frame(input bit sel, input logic [7:0] data, input bit bad_par,
                            input bit glitch, input bit bad_stop);
    int   p;
    int   nb;
    logic fb[11];
    logic v;
    logic pb;
    p = sel ? 16 : 10;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i+1] = data[i];
    nb = 9;
    if (sel) begin
      pb = ~(^data);
      fb[9] = bad_par ? ~pb : pb;
      nb = 10;
    end
    fb[nb] = bad_stop ? 1'b0 : 1'b1;
    nb++;
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        v = fb[i];
        if (glitch && i >= 1 && i <= 8 && c == p / 2) v = ~v;
        if (sel) b_drv = v; else a_drv = v;
      end
    end
    for (int c = 0; c < 2 * p; c++) begin
      @(negedge clk);
      if (sel) b_drv = 1'b1; else a_drv = 1'b1;
    end
  endtask

  // Wait (bounded) for an RX word, compare with the scoreboard head, then pop it.
  task automatic rx_check(input bit sel, input string name);
    int          t;
    logic        dv;
    logic [10:0] exp;
    logic [10:0] act;
    t = 0;
    dv = sel ? b_rx_dv : a_rx_dv;
    while (!dv && t < 3000) begin
      @(negedge clk);
      t++;
      dv = sel ? b_rx_dv : a_rx_dv;
    end
    chk({name, " dv"}, {31'd0, dv}, 32'd1);
    if ((sel ? q_b.size() : q_a.size()) == 0) begin
      chk({name, " queue"}, 32'd0, 32'd1);
    end else begin
      exp = sel ? q_b.pop_front() : q_a.pop_front();
      if (dv) begin
        act = sel ? {b_rx_err, b_rx_d} : {a_rx_err, a_rx_d};
        chk(name, {21'd0, act}, {21'd0, exp});
        if (sel) b_rx_dr = 1'b1; else a_rx_dr = 1'b1;
        @(negedge clk);
        a_rx_dr = 1'b0;
        b_rx_dr = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_div = 16'd9;  b_div = 16'd15;
    a_tx_d = 8'h00; a_tx_dv = 1'b0; b_tx_d = 8'h00; b_tx_dv = 1'b0;
    a_rx_dr = 1'b0; b_rx_dr = 1'b0; a_clr = 1'b0; b_clr = 1'b0;
    a_loop = 1'b0;  a_drv = 1'b1;   b_drv = 1'b1;

    vecs[0] = '{1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A, 3'b000};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000};
    vecs[2] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 3'b010};
    vecs[3] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h55, 3'b001};
    vecs[4] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 3'b000};
    vecs[5] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000};
    vecs[6] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 3'b001};
    vecs[7] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A, 3'b000};
    vecs[8] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 3'b111};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst a uart_tx", {31'd0, a_tx_line}, 32'd1);
    chk("rst a tx_dr",   {31'd0, a_tx_dr},   32'd1);
    chk("rst a rx_dv",   {31'd0, a_rx_dv},   32'd0);
    chk("rst a rx_d",    {24'd0, a_rx_d},    32'd0);
    chk("rst a rx_err",  {29'd0, a_rx_err},  32'd0);
    chk("rst a ovr",     {31'd0, a_ovr},     32'd0);
    chk("rst a busy",    {31'd0, a_busy},    32'd0);
    chk("rst b state",   {26'd0, b_tx_line, b_tx_dr, b_busy, b_ovr, b_rx_dv, |b_rx_err}, 32'h30);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].sel) q_b.push_back({vecs[i].exp_err, vecs[i].exp_d});
      else             q_a.push_back({vecs[i].exp_err, vecs[i].exp_d});
      send_frame(vecs[i].sel, vecs[i].data, vecs[i].bad_par, vecs[i].glitch, vecs[i].bad_stop);
      rx_check(vecs[i].sel, $sformatf("vec%0d", i));
    end

    // Short low pulse on an idle line is a glitch: no push
    @(negedge clk); a_drv = 1'b0;
    @(negedge clk);
    @(negedge clk); a_drv = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch no push", {31'd0, a_rx_dv}, 32'd0);

    // Held break: exactly one entry, then a clean frame
    q_a.push_back({3'b110, 8'h00});
    @(negedge clk); a_drv = 1'b0;
    repeat (120) @(negedge clk);
    a_drv = 1'b1;
    repeat (30) @(negedge clk);
    rx_check(1'b0, "break");
    repeat (100) @(negedge clk);
    chk("break single", {31'd0, a_rx_dv}, 32'd0);
    q_a.push_back({3'b000, 8'h81});
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
    rx_check(1'b0, "after break");

    // Loopback of three back-to-back words
    a_loop = 1'b1;
    q_a.push_back({3'b000, 8'hA5});
    q_a.push_back({3'b000, 8'h3C});
    q_a.push_back({3'b000, 8'hFF});
    @(negedge clk); a_tx_d = 8'hA5; a_tx_dv = 1'b1;
    @(negedge clk);
    chk("lb tx N+1", {31'd0, a_tx_line}, 32'd1);
    a_tx_d = 8'h3C;
    @(negedge clk);
    chk("lb tx N+2", {31'd0, a_tx_line}, 32'd0);
    a_tx_d = 8'hFF;
    @(negedge clk); a_tx_dv = 1'b0;
    for (int k = 2; k <= 305; k++) begin
      @(negedge clk);
      if (k == 99)  chk("lb stop1",   {31'd0, a_tx_line}, 32'd1);
      if (k == 100) chk("lb start2",  {31'd0, a_tx_line}, 32'd0);
      if (k == 150) chk("lb busy",    {31'd0, a_busy},    32'd1);
      if (k == 199) chk("lb stop2",   {31'd0, a_tx_line}, 32'd1);
      if (k == 200) chk("lb start3",  {31'd0, a_tx_line}, 32'd0);
      if (k == 299) chk("lb stop3",   {31'd0, a_tx_line}, 32'd1);
      if (k == 305) chk("lb idle",    {31'd0, a_busy},    32'd0);
    end
    rx_check(1'b0, "lb0");
    rx_check(1'b0, "lb1");
    rx_check(1'b0, "lb2");
    a_loop = 1'b0;

    // Overrun on a 4-deep RX FIFO
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) q_a.push_back({3'b000, 8'(i)});
      send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 4) chk("ovr full no flag", {31'd0, a_ovr}, 32'd0);
    end
    repeat (10) @(negedge clk);
    chk("ovr set", {31'd0, a_ovr}, 32'd1);
    @(negedge clk); a_clr = 1'b1;
    @(negedge clk); a_clr = 1'b0;
    chk("ovr clr", {31'd0, a_ovr}, 32'd0);
    for (int i = 0; i < 4; i++) rx_check(1'b0, $sformatf("ovr pop%0d", i));
    chk("ovr drained", {31'd0, a_rx_dv}, 32'd0);

    // Reset mid-frame with words queued and an RX entry pending
    send_frame(1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
    chk("rst pre rx_dv", {31'd0, a_rx_dv}, 32'd1);
    @(negedge clk); a_tx_d = 8'h11; a_tx_dv = 1'b1;
    @(negedge clk); a_tx_d = 8'h22;
    @(negedge clk); a_tx_d = 8'h33;
    @(negedge clk); a_tx_d = 8'h44;
    @(negedge clk); a_tx_dv = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst pre busy", {31'd0, a_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async uart_tx", {31'd0, a_tx_line}, 32'd1);
    chk("rst async busy",    {31'd0, a_busy},    32'd0);
    chk("rst async tx_dr",   {31'd0, a_tx_dr},   32'd1);
    chk("rst async rx_dv",   {31'd0, a_rx_dv},   32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    a_loop = 1'b1;
    q_a.push_back({3'b000, 8'h42});
    @(negedge clk); a_tx_d = 8'h42; a_tx_dv = 1'b1;
    @(negedge clk); a_tx_dv = 1'b0;
    rx_check(1'b0, "post rst");
    a_loop = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
